mem_stage: RTL and testbench
============================

Name: mem_stage

Overview:
- Pipeline stage directly downstream of the execute stage. Consumes the EX/MEM register outputs.
- Performs data-memory loads and stores over a req/ack bus, with byte/half lane steering and sign extension.
- Supplies a free-running LFSR random value and selects the write-back data.
- Holds the MEM/WB pipeline register and drives stall_mem back to execute while a memory access is outstanding.

Parameters:
- LFSR_SEED, 32'hACE1_2025: LFSR value after reset; must be non-zero.
- TIMEOUT_CYC, 64: cycles to wait for dmem_ack before abort (used only with the optional feature).

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- next_pc_mem  in  32  PC+4 of the instruction in MEM
- write_data_mem  in  32  store data
- alu_result_mem  in  32  ALU result / memory address
- wb_sel_mem  in  2  00 alu, 01 mem, 10 next_pc, 11 alu
- read_width_mem  in  2  00 byte, 01 half, 10 word (shared by loads and stores)
- wrt_dst_mem  in  5  destination register
- random_mem  in  1  result is the LFSR value; overrides wb_sel
- mem_wrt_en_mem  in  1  store
- reg_wrt_en_mem  in  1  register write
- read_unsigned_mem  in  1  zero-extend the load
- rd_en_mem  in  1  load
- rdi_mem  in  1  sideband flag, piped to WB
- dmem_req  out  1  bus request
- dmem_we  out  1  write
- dmem_addr  out  32  word address ({alu_result_mem[31:2],2'b00})
- dmem_be  out  4  byte enables
- dmem_wdata  out  32  lane-replicated store data
- dmem_rdata  in  32  read data, valid with ack
- dmem_ack  in  1  one-cycle completion
- stall_mem  out  1  hold EX/MEM
- misalign_err  out  1  one-cycle pulse
- wbdata_wb  out  32  registered write-back data (also the forwarding source)
- wrt_dst_wb  out  5  registered destination
- reg_wrt_en_wb  out  1  registered write enable
- rdi_wb  out  1  registered rdi

Behaviour:
- Reset (async): all outputs 0; FSM to IDLE; LFSR to LFSR_SEED; an outstanding request is dropped, with no retry.
- access = rd_en_mem | mem_wrt_en_mem.
- Misaligned when: half with addr[0]=1, word with addr[1:0]!=0, or width 11.
  - No bus access; misalign_err=1 for that cycle; stall_mem=0.
  - MEM/WB captures a bubble (reg_wrt_en_wb=0).
- FSM IDLE:
  - On an aligned access: dmem_req=1 combinationally, go to BUSY.
  - If dmem_ack arrives in the same cycle: complete immediately and stay in IDLE.
- FSM BUSY:
  - dmem_req, we, addr, be and wdata are held stable until dmem_ack.
  - On ack: return to IDLE.
- stall_mem = aligned access & ~dmem_ack, in both states.
  - Minimum load/store latency is 1 cycle (same-cycle ack).
  - Each wait cycle adds one cycle.
- dmem_ack while no request is pending is ignored.
- Store byte enables:
  - byte: 1<<addr[1:0], wdata = {4{wd[7:0]}}.
  - half: 0011 or 1100 by addr[1], wdata = {2{wd[15:0]}}.
  - word: 1111.
- Load: select the lane by addr[1:0]/addr[1]; sign-extend, or zero-extend if read_unsigned_mem.
- Result selection: random_mem ? lfsr : wb_sel (01 uses load data).
- MEM/WB register:
  - While stall_mem=1: capture a bubble (reg_wrt_en_wb=0, other fields don't-care but deterministic: hold).
  - Otherwise: capture result, wrt_dst, reg_wrt_en, rdi.
- LFSR: 32-bit Galois, taps mask 32'h80200003, shifts right every cycle regardless of stall. Its value is sampled in the capture cycle.

Optional Feature:
- Macro DMEM_TIMEOUT_EN.
- When defined:
  - A wait counter resets on entering BUSY and increments each BUSY cycle.
  - When it reaches TIMEOUT_CYC without ack: drop dmem_req, pulse misalign_err? No — pulse dedicated output bus_err (1 bit, reset 0, port present only under the macro).
  - Write back 32'hDEAD_BEEF for a load (stores write nothing), deassert stall_mem that cycle, return to IDLE.
- When undefined: no counter and no bus_err port; BUSY waits indefinitely.

Test Plan:
- Reset then idle: all outputs 0.
  - Cycle 1 after reset: wbdata_wb=0.
  - With random_mem=1, alu path: wbdata_wb = LFSR_SEED advanced once.
- Word load at addr 0x100, ack after 3 cycles, rdata 0x89ABCDEF:
  - stall_mem high for 3 cycles; reg_wrt_en_wb=0 for those cycles.
  - Then wbdata_wb=0x89ABCDEF.
- Byte loads at 0x103 with rdata 0x80112233:
  - signed -> 0xFFFFFF80.
  - unsigned -> 0x00000080.
  - Ack in the same cycle: no stall.
- Half store of 0x0000BEEF at 0x202: dmem_be=1100, dmem_wdata=0xBEEFBEEF, dmem_addr=0x200, dmem_we=1.
- Word load at 0x101: misalign_err pulse, dmem_req=0, stall_mem=0, reg_wrt_en_wb=0.
- Reset asserted mid-BUSY: dmem_req drops immediately.
  - After release: FSM idle, next load issues normally.
  - With DMEM_TIMEOUT_EN: withholding ack for 64 cycles gives a bus_err pulse and wbdata_wb=0xDEADBEEF.

Source files
------------

// File: rtl/mem_stage.sv
// MEM pipeline stage: data-memory req/ack access with lane steering, LFSR source and MEM/WB register.
// Optional macro DMEM_TIMEOUT_EN adds a BUSY wait counter, abort after TIMEOUT_CYC cycles and a bus_err port.
module mem_stage #(
   parameter logic [31:0] LFSR_SEED   = 32'hACE1_2025,
   parameter int unsigned TIMEOUT_CYC = 64
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] next_pc_mem,
   input  logic [31:0] write_data_mem,
   input  logic [31:0] alu_result_mem,
   input  logic [1:0]  wb_sel_mem,
   input  logic [1:0]  read_width_mem,
   input  logic [4:0]  wrt_dst_mem,
   input  logic        random_mem,
   input  logic        mem_wrt_en_mem,
   input  logic        reg_wrt_en_mem,
   input  logic        read_unsigned_mem,
   input  logic        rd_en_mem,
   input  logic        rdi_mem,
   output logic        dmem_req,
   output logic        dmem_we,
   output logic [31:0] dmem_addr,
   output logic [3:0]  dmem_be,
   output logic [31:0] dmem_wdata,
   input  logic [31:0] dmem_rdata,
   input  logic        dmem_ack,
   output logic        stall_mem,
   output logic        misalign_err,
`ifdef DMEM_TIMEOUT_EN
   output logic        bus_err,
`endif
   output logic [31:0] wbdata_wb,
   output logic [4:0]  wrt_dst_wb,
   output logic        reg_wrt_en_wb,
   output logic        rdi_wb
);

   localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

   if (LFSR_SEED == 32'h0 || TIMEOUT_CYC == 0) begin : g_bad_param
      $error("mem_stage: LFSR_SEED and TIMEOUT_CYC must be non-zero");
   end

   typedef enum logic {ST_IDLE, ST_BUSY} state_e;

   state_e      state_q, state_d;
   logic [31:0] lfsr_q, lfsr_d;
   logic        we_q, we_d;
   logic [31:0] addr_q, addr_d;
   logic [3:0]  be_q, be_d;
   logic [31:0] wdata_q, wdata_d;
   logic [31:0] wbdata_q, wbdata_d;
   logic [4:0]  wrt_dst_q, wrt_dst_d;
   logic        reg_wrt_en_q, reg_wrt_en_d;
   logic        rdi_q, rdi_d;
`ifdef DMEM_TIMEOUT_EN
   logic [31:0] wait_cnt_q, wait_cnt_d;
`endif

   logic        access, bad_align, misaligned, aligned_acc;
   logic        busy, timeout, bus_vld;
   logic [31:0] addr_live, wdata_live, load_data, result;
   logic [3:0]  be_live;
   logic [7:0]  rd_byte;
   logic [15:0] rd_half;

   always_comb begin : decode
      access    = rd_en_mem | mem_wrt_en_mem;
      addr_live = {alu_result_mem[31:2], 2'b00};
      unique case (read_width_mem)
         2'b00:   bad_align = 1'b0;
         2'b01:   bad_align = alu_result_mem[0];
         2'b10:   bad_align = |alu_result_mem[1:0];
         default: bad_align = 1'b1;
      endcase
      misaligned  = access & bad_align;
      aligned_acc = access & ~bad_align;

      unique case (read_width_mem)
         2'b00: begin
            be_live    = 4'b0001 << alu_result_mem[1:0];
            wdata_live = {4{write_data_mem[7:0]}};
         end
         2'b01: begin
            be_live    = alu_result_mem[1] ? 4'b1100 : 4'b0011;
            wdata_live = {2{write_data_mem[15:0]}};
         end
         default: begin
            be_live    = 4'b1111;
            wdata_live = write_data_mem;
         end
      endcase

      unique case (alu_result_mem[1:0])
         2'b00:   rd_byte = dmem_rdata[7:0];
         2'b01:   rd_byte = dmem_rdata[15:8];
         2'b10:   rd_byte = dmem_rdata[23:16];
         default: rd_byte = dmem_rdata[31:24];
      endcase
      rd_half = alu_result_mem[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
      unique case (read_width_mem)
         2'b00:   load_data = read_unsigned_mem ? {24'h0, rd_byte} : {{24{rd_byte[7]}}, rd_byte};
         2'b01:   load_data = read_unsigned_mem ? {16'h0, rd_half} : {{16{rd_half[15]}}, rd_half};
         default: load_data = dmem_rdata;
      endcase

      if (random_mem) begin
         result = lfsr_q;
      end else begin
         unique case (wb_sel_mem)
            2'b01:   result = load_data;
            2'b10:   result = next_pc_mem;
            default: result = alu_result_mem;
         endcase
      end
   end

   assign busy = (state_q == ST_BUSY);

`ifdef DMEM_TIMEOUT_EN
   assign timeout = busy & ~dmem_ack & (wait_cnt_q == TIMEOUT_CYC - 1);
   assign bus_err = timeout;
`else
   assign timeout = 1'b0;
`endif

   // In BUSY the bus is driven from the copy latched on entry; gating with rst_n drops the request during reset.
   assign bus_vld      = rst_n & (busy ? ~timeout : aligned_acc);
   assign dmem_req     = bus_vld;
   assign dmem_we      = bus_vld & (busy ? we_q : mem_wrt_en_mem);
   assign dmem_addr    = bus_vld ? (busy ? addr_q : addr_live) : '0;
   assign dmem_be      = bus_vld ? (busy ? be_q : be_live) : '0;
   assign dmem_wdata   = bus_vld ? (busy ? wdata_q : wdata_live) : '0;
   assign stall_mem    = rst_n & aligned_acc & ~dmem_ack & ~timeout;
   assign misalign_err = rst_n & misaligned;

   assign wbdata_wb     = wbdata_q;
   assign wrt_dst_wb    = wrt_dst_q;
   assign reg_wrt_en_wb = reg_wrt_en_q;
   assign rdi_wb        = rdi_q;

   always_comb begin : next_state
      state_d = state_q;
      we_d    = we_q;
      addr_d  = addr_q;
      be_d    = be_q;
      wdata_d = wdata_q;
`ifdef DMEM_TIMEOUT_EN
      wait_cnt_d = wait_cnt_q;
`endif
      unique case (state_q)
         ST_IDLE: begin
            if (aligned_acc && !dmem_ack) begin
               state_d = ST_BUSY;
               we_d    = mem_wrt_en_mem;
               addr_d  = addr_live;
               be_d    = be_live;
               wdata_d = wdata_live;
`ifdef DMEM_TIMEOUT_EN
               wait_cnt_d = '0;
`endif
            end
         end
         default: begin
            if (dmem_ack || timeout) state_d = ST_IDLE;
`ifdef DMEM_TIMEOUT_EN
            wait_cnt_d = wait_cnt_q + 32'd1;
`endif
         end
      endcase

      lfsr_d = {1'b0, lfsr_q[31:1]} ^ (lfsr_q[0] ? LFSR_TAPS : '0);

      wbdata_d     = wbdata_q;
      wrt_dst_d    = wrt_dst_q;
      rdi_d        = rdi_q;
      reg_wrt_en_d = 1'b0;
      if (!stall_mem && !misaligned) begin
         wrt_dst_d = wrt_dst_mem;
         rdi_d     = rdi_mem;
         if (timeout) begin
            wbdata_d     = 32'hDEAD_BEEF;
            reg_wrt_en_d = reg_wrt_en_mem & rd_en_mem;
         end else begin
            wbdata_d     = result;
            reg_wrt_en_d = reg_wrt_en_mem;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         lfsr_q       <= LFSR_SEED;
         we_q         <= 1'b0;
         addr_q       <= '0;
         be_q         <= '0;
         wdata_q      <= '0;
         wbdata_q     <= '0;
         wrt_dst_q    <= '0;
         reg_wrt_en_q <= 1'b0;
         rdi_q        <= 1'b0;
`ifdef DMEM_TIMEOUT_EN
         wait_cnt_q   <= '0;
`endif
      end else begin
         state_q      <= state_d;
         lfsr_q       <= lfsr_d;
         we_q         <= we_d;
         addr_q       <= addr_d;
         be_q         <= be_d;
         wdata_q      <= wdata_d;
         wbdata_q     <= wbdata_d;
         wrt_dst_q    <= wrt_dst_d;
         reg_wrt_en_q <= reg_wrt_en_d;
         rdi_q        <= rdi_d;
`ifdef DMEM_TIMEOUT_EN
         wait_cnt_q   <= wait_cnt_d;
`endif
      end
   end

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: directed stimulus pushes expected write-backs, a monitor pops on reg_wrt_en_wb.
module tb_mem_stage;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] next_pc_mem, write_data_mem, alu_result_mem;
   logic [1:0]  wb_sel_mem, read_width_mem;
   logic [4:0]  wrt_dst_mem;
   logic        random_mem, mem_wrt_en_mem, reg_wrt_en_mem, read_unsigned_mem, rd_en_mem, rdi_mem;
   logic        dmem_req, dmem_we, dmem_ack, stall_mem, misalign_err;
   logic [31:0] dmem_addr, dmem_wdata, dmem_rdata, wbdata_wb;
   logic [3:0]  dmem_be;
   logic [4:0]  wrt_dst_wb;
   logic        reg_wrt_en_wb, rdi_wb;
`ifdef DMEM_TIMEOUT_EN
   logic        bus_err;
`endif

   always #5 clk = ~clk;

   mem_stage dut (
      .clk(clk), .rst_n(rst_n),
      .next_pc_mem(next_pc_mem), .write_data_mem(write_data_mem), .alu_result_mem(alu_result_mem),
      .wb_sel_mem(wb_sel_mem), .read_width_mem(read_width_mem), .wrt_dst_mem(wrt_dst_mem),
      .random_mem(random_mem), .mem_wrt_en_mem(mem_wrt_en_mem), .reg_wrt_en_mem(reg_wrt_en_mem),
      .read_unsigned_mem(read_unsigned_mem), .rd_en_mem(rd_en_mem), .rdi_mem(rdi_mem),
      .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_be(dmem_be),
      .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
      .stall_mem(stall_mem), .misalign_err(misalign_err),
`ifdef DMEM_TIMEOUT_EN
      .bus_err(bus_err),
`endif
      .wbdata_wb(wbdata_wb), .wrt_dst_wb(wrt_dst_wb), .reg_wrt_en_wb(reg_wrt_en_wb), .rdi_wb(rdi_wb)
   );

   typedef struct {
      logic [31:0] data;
      logic [4:0]  dst;
   } exp_t;

   exp_t exp_q[$];
   int   total = 0;
   int   bad   = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %h want %h", name, act, req);
      end
   endtask

   task automatic push_exp(input logic [31:0] data, input logic [4:0] dst);
      exp_t e;
      e.data = data;
      e.dst  = dst;
      exp_q.push_back(e);
   endtask

   task automatic idle();
      next_pc_mem = '0; write_data_mem = '0; alu_result_mem = '0;
      wb_sel_mem = '0; read_width_mem = '0; wrt_dst_mem = '0;
      random_mem = 1'b0; mem_wrt_en_mem = 1'b0; reg_wrt_en_mem = 1'b0;
      read_unsigned_mem = 1'b0; rd_en_mem = 1'b0; rdi_mem = 1'b0;
   endtask

   task automatic load(input logic [31:0] addr, input logic [1:0] width, input logic uns, input logic [4:0] dst);
      idle();
      rd_en_mem = 1'b1; read_width_mem = width; alu_result_mem = addr;
      read_unsigned_mem = uns; wb_sel_mem = 2'b01; reg_wrt_en_mem = 1'b1; wrt_dst_mem = dst;
   endtask

   task automatic next();
      @(negedge clk);
   endtask

   // Monitor: every write-back the DUT presents must match the oldest expected entry.
   initial begin
      forever begin
         @(negedge clk);
         if (rst_n === 1'b1 && reg_wrt_en_wb === 1'b1) begin
            if (exp_q.size() == 0) begin
               total++;
               bad++;
               $display("FAIL wb_unexpected: got data %h dst %0d want no write-back", wbdata_wb, wrt_dst_wb);
            end else begin
               exp_t e;
               e = exp_q.pop_front();
               chk("wb_data", wbdata_wb, e.data);
               chk("wb_dst", {27'h0, wrt_dst_wb}, {27'h0, e.dst});
            end
         end
      end
   end

   initial begin
      idle();
      dmem_ack = 1'b0;
      dmem_rdata = '0;
      rst_n = 1'b0;

      next(); #1;
      chk("rst_req", dmem_req, 0);
      chk("rst_stall", stall_mem, 0);
      chk("rst_wbdata", wbdata_wb, 0);
      chk("rst_wen", reg_wrt_en_wb, 0);
      chk("rst_misalign", misalign_err, 0);
      next(); rst_n = 1'b1;

      next(); #1;
      chk("wb_after_rst", wbdata_wb, 0);
      chk("wen_after_rst", reg_wrt_en_wb, 0);
      random_mem = 1'b1; reg_wrt_en_mem = 1'b1; wrt_dst_mem = 5'd5;
      push_exp(32'hD650_9011, 5'd5);

      next(); idle(); reg_wrt_en_mem = 1'b1; wrt_dst_mem = 5'd2; alu_result_mem = 32'h1234;
      push_exp(32'h0000_1234, 5'd2);
      next(); idle(); reg_wrt_en_mem = 1'b1; wrt_dst_mem = 5'd11; wb_sel_mem = 2'b10;
      next_pc_mem = 32'h44; alu_result_mem = 32'h99;
      push_exp(32'h0000_0044, 5'd11);
      next(); idle(); reg_wrt_en_mem = 1'b1; wrt_dst_mem = 5'd12; wb_sel_mem = 2'b11;
      alu_result_mem = 32'hCAFE_0000;
      push_exp(32'hCAFE_0000, 5'd12);
      next(); idle();

      // Word load, three wait cycles
      next(); load(32'h100, 2'b10, 1'b0, 5'd7);
      push_exp(32'h89AB_CDEF, 5'd7);
      #1;
      chk("wl_req", dmem_req, 1);
      chk("wl_stall", stall_mem, 1);
      chk("wl_addr", dmem_addr, 32'h100);
      chk("wl_we", dmem_we, 0);
      for (int i = 0; i < 2; i++) begin
         next(); #1;
         chk("wl_busy_stall", stall_mem, 1);
         chk("wl_busy_req", dmem_req, 1);
         chk("wl_busy_addr", dmem_addr, 32'h100);
         chk("wl_bubble", reg_wrt_en_wb, 0);
      end
      next(); dmem_ack = 1'b1; dmem_rdata = 32'h89AB_CDEF; #1;
      chk("wl_ack_stall", stall_mem, 0);
      chk("wl_ack_bubble", reg_wrt_en_wb, 0);
      next(); dmem_ack = 1'b0; idle();

      // Byte and half loads, same-cycle ack
      next(); load(32'h103, 2'b00, 1'b0, 5'd8);
      dmem_ack = 1'b1; dmem_rdata = 32'h8011_2233;
      push_exp(32'hFFFF_FF80, 5'd8);
      #1;
      chk("lb_stall", stall_mem, 0);
      chk("lb_req", dmem_req, 1);
      chk("lb_addr", dmem_addr, 32'h100);
      next(); load(32'h103, 2'b00, 1'b1, 5'd9);
      push_exp(32'h0000_0080, 5'd9);
      #1;
      chk("lbu_stall", stall_mem, 0);
      next(); load(32'h102, 2'b01, 1'b0, 5'd13);
      push_exp(32'hFFFF_8011, 5'd13);
      next(); dmem_ack = 1'b0; idle();

      // Half store, one wait cycle
      next(); mem_wrt_en_mem = 1'b1; read_width_mem = 2'b01;
      alu_result_mem = 32'h202; write_data_mem = 32'h0000_BEEF;
      #1;
      chk("sh_be", dmem_be, 4'b1100);
      chk("sh_wdata", dmem_wdata, 32'hBEEF_BEEF);
      chk("sh_addr", dmem_addr, 32'h200);
      chk("sh_we", dmem_we, 1);
      chk("sh_stall", stall_mem, 1);
      next(); #1;
      chk("sh_busy_be", dmem_be, 4'b1100);
      chk("sh_busy_wdata", dmem_wdata, 32'hBEEF_BEEF);
      dmem_ack = 1'b1; #1;
      chk("sh_ack_stall", stall_mem, 0);
      next(); dmem_ack = 1'b1; idle();
      mem_wrt_en_mem = 1'b1; read_width_mem = 2'b00; alu_result_mem = 32'h201; write_data_mem = 32'h1234_56A5;
      #1;
      chk("sb_be", dmem_be, 4'b0010);
      chk("sb_wdata", dmem_wdata, 32'hA5A5_A5A5);
      next(); dmem_ack = 1'b0; idle();

      // Misaligned accesses
      next(); load(32'h101, 2'b10, 1'b0, 5'd3); #1;
      chk("mis_err", misalign_err, 1);
      chk("mis_req", dmem_req, 0);
      chk("mis_stall", stall_mem, 0);
      next(); idle(); mem_wrt_en_mem = 1'b1; read_width_mem = 2'b11; #1;
      chk("mis_w11_err", misalign_err, 1);
      chk("mis_w11_req", dmem_req, 0);
      chk("mis_bubble", reg_wrt_en_wb, 0);
      next(); idle(); #1;
      chk("mis_pulse_end", misalign_err, 0);
      chk("mis_bubble2", reg_wrt_en_wb, 0);

      // Stray ack with nothing pending
      next(); dmem_ack = 1'b1; #1;
      chk("stray_req", dmem_req, 0);
      chk("stray_stall", stall_mem, 0);
      next(); dmem_ack = 1'b0;

      // Reset asserted while BUSY
      next(); load(32'h300, 2'b10, 1'b0, 5'd4); #1;
      chk("rb_req", dmem_req, 1);
      next(); #1;
      chk("rb_busy_req", dmem_req, 1);
      #2 rst_n = 1'b0; #1;
      chk("rb_req_drop", dmem_req, 0);
      chk("rb_stall_drop", stall_mem, 0);
      chk("rb_addr_drop", dmem_addr, 0);
      next(); rst_n = 1'b1; idle();
      next(); load(32'h104, 2'b10, 1'b0, 5'd6);
      push_exp(32'h1234_5678, 5'd6);
      #1;
      chk("ra_req", dmem_req, 1);
      chk("ra_addr", dmem_addr, 32'h104);
      chk("ra_stall", stall_mem, 1);
      next(); dmem_ack = 1'b1; dmem_rdata = 32'h1234_5678; #1;
      chk("ra_busy_addr", dmem_addr, 32'h104);
      chk("ra_ack_stall", stall_mem, 0);
      next(); dmem_ack = 1'b0; idle();

`ifdef DMEM_TIMEOUT_EN
      begin
         int k;
         k = 0;
         next(); load(32'h400, 2'b10, 1'b0, 5'd10);
         push_exp(32'hDEAD_BEEF, 5'd10);
         for (int c = 1; c <= 200 && k == 0; c++) begin
            next(); #1;
            if (bus_err === 1'b1) begin
               k = c;
               chk("to_stall", stall_mem, 0);
               chk("to_req", dmem_req, 0);
            end
         end
         chk("to_cycle", k, 64);
         next(); idle(); #1;
         chk("to_pulse_end", bus_err, 0);
      end
`endif

      next(); next(); next();
      chk("queue_empty", exp_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1);
   end

endmodule
